tag_tx_encoder: RTL
===================

TAG_TX_ENCODER -- requirements
Module: tag_tx_encoder

Interface
REQ-001 clk  in  1  half-symbol clock (2x BLF); all state changes on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears every register immediately.
REQ-003 tx_start  in  1  one-cycle pulse that begins a reply; sampled only in IDLE.
REQ-004 trext  in  1  sampled with tx_start; 1 = prepend the pilot tone.
REQ-005 crc_append  in  1  sampled with tx_start; 1 = append CRC-16 after the last data bit.
REQ-006 abort  in  1  synchronous abort, e.g. new command received; highest priority below reset.
REQ-007 bit_in  in  1  next payload bit from the memory interface serializer.
REQ-008 bit_last  in  1  qualifies bit_in as the final payload bit.
REQ-009 bit_req  out  1  one-cycle request for the next payload bit.
REQ-010 tx_out  out  1  FM0 backscatter level to the modulator.
REQ-011 tx_busy  out  1  high from the cycle after an accepted tx_start until DONE is left.
REQ-012 tx_done  out  1  one-cycle pulse at end of signalling.

Function
REQ-013 States: IDLE, PILOT, PREAMBLE, DATA, CRC, DUMMY, DONE.
REQ-014 Symbol timing: 1 symbol = 2 clk cycles, H0 then H1; tx_out registered, changes only on clk.
REQ-015 FM0 encoding:
- tx_out inverts at every symbol start.
- A data-0 additionally inverts at the H0->H1 boundary.
- A data-1 holds its level for both halves.
REQ-016 IDLE:
- tx_out = 0.
- tx_start goes to PILOT if trext = 1, else to PREAMBLE, on the next cycle.
REQ-017 PILOT: 12 FM0 data-0 symbols (24 cycles), then PREAMBLE.
REQ-018 PREAMBLE:
- Emits the fixed 12-half-symbol pattern 1,1,0,1,0,0,1,0,0,0,1,1, leftmost first; this includes the FM0 violation.
- The level state after the pattern is 1.
REQ-019 Bit handshake:
- bit_req pulses in H0 of the current symbol.
- bit_in and bit_last are sampled at the end of the following cycle (H1).
- The sampled bit is encoded in the next symbol.
- The first request is issued in the second-to-last half-symbol of PREAMBLE.
REQ-020 DATA:
- After the symbol carrying bit_last = 1, go to CRC if crc_append = 1, else to DUMMY.
- No bit_req is issued after bit_last is sampled.
REQ-021 CRC-16 algorithm:
- Polynomial x^16+x^12+x^5+1, preset 0xFFFF.
- Updated on every sampled payload bit, MSB-first.
- The ones-complement of the register is transmitted MSB-first, 16 symbols.
REQ-022 DUMMY: one data-1 symbol, then DONE.
REQ-023 DONE: lasts 1 cycle; tx_done = 1, tx_out = 0, then return to IDLE.
REQ-024 Ignored inputs:
- tx_start while not in IDLE is ignored.
- bit_in and bit_last outside the sample cycle are ignored.
REQ-025 Abort: from any state go to IDLE next cycle.
- tx_out = 0, tx_busy = 0, bit_req = 0.
- No tx_done pulse.
- CRC re-preset to 0xFFFF.
REQ-026 Simultaneous abort and tx_start in IDLE: abort wins and the start is dropped.
REQ-027 A single-bit payload (bit_last set on the first sample) is legal and encodes exactly one data symbol.

Reset
REQ-028 Reset outputs: tx_out = 0, bit_req = 0, tx_busy = 0, tx_done = 0.
REQ-029 Reset internals: state = IDLE, CRC = 0xFFFF, level = 0, counters = 0.
REQ-030 Reset mid-reply discards the reply; no tx_done is produced.

Configuration
REQ-031 Macro TAG_TX_CRC16_EN defined: CRC generator and CRC state present; behaviour per REQ-021.
REQ-032 Macro TAG_TX_CRC16_EN undefined:
- CRC logic and the CRC state are absent.
- crc_append is ignored; DATA always proceeds to DUMMY.

Verification
REQ-033 Payload and CRC:
- Stimulus: trext = 0, crc_append = 1, payload ASCII "123456789" (72 bits).
- Response: decoded CRC field = 0xD64E.
- Total cycles from tx_start to tx_done = 1 + 12 + 144 + 32 + 2 + 1.
REQ-034 Pilot:
- Stimulus: trext = 1, crc_append = 0, payload 16'hA5F0.
- Response: 24 alternating-half pilot cycles, then preamble, 16 data symbols, dummy-1.
- Exactly 16 bit_req pulses.
REQ-035 Single-bit payload:
- Stimulus: payload 1'b0 with bit_last on the first sample.
- Response: tx_out = 0,1 across that symbol, then dummy-1, then tx_done.
REQ-036 Abort:
- Stimulus: abort asserted at the 5th DATA symbol.
- Response: next cycle tx_out = 0, tx_busy = 0, no tx_done.
- A following reply carrying "123456789" again yields CRC 0xD64E.
REQ-037 Asynchronous reset:
- Stimulus: reset asserted mid-CRC, between clock edges.
- Response: outputs reach their reset values before the next clk edge.
REQ-038 Ignored restart:
- Stimulus: tx_start pulsed during PREAMBLE.
- Response: no restart; the reply completes unchanged.

Source files
------------

// File: rtl/tag_tx_encoder.sv
// -----------------------------------------------------------------------------
// tag_tx_encoder
//
// Purpose
//   Tag-to-reader reply encoder. It emits an FM0 backscatter waveform made of an
//   optional pilot tone, a fixed preamble, a payload streamed in one bit at a
//   time from the memory serializer, an optional CRC-16, and a dummy data-1.
//   One clk cycle is one half-symbol (clk = 2x BLF).
//
// Configuration
//   TAG_TX_CRC16_EN  defined   : CRC-16 generator (x^16+x^12+x^5+1, preset
//                                0xFFFF, complemented on air) is built in and
//                                crc_append selects whether it is sent.
//                    undefined : no CRC hardware; crc_append is ignored and
//                                DATA always proceeds to DUMMY.
//
// Ports
//   clk         in   half-symbol clock, rising edge active
//   reset       in   asynchronous active-high reset
//   tx_start    in   one-cycle start pulse, accepted only in IDLE
//   trext       in   sampled with tx_start: 1 = send the 12-symbol pilot tone
//   crc_append  in   sampled with tx_start: 1 = append CRC-16
//   abort       in   synchronous abort, returns to IDLE on the next cycle
//   bit_in      in   payload bit from the serializer
//   bit_last    in   marks bit_in as the final payload bit
//   bit_req     out  one-cycle request for the next payload bit (H0 of a symbol)
//   tx_out      out  registered FM0 level to the modulator
//   tx_busy     out  high while a reply is in progress (PILOT..DONE)
//   tx_done     out  one-cycle pulse in the DONE state
// -----------------------------------------------------------------------------
module tag_tx_encoder (
  input  logic clk,
  input  logic reset,
  input  logic tx_start,
  input  logic trext,
  input  logic crc_append,
  input  logic abort,
  input  logic bit_in,
  input  logic bit_last,
  output logic bit_req,
  output logic tx_out,
  output logic tx_busy,
  output logic tx_done
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PILOT    = 3'd1;
  localparam logic [2:0] ST_PREAMBLE = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_CRC      = 3'd4;
  localparam logic [2:0] ST_DUMMY    = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  // Preamble half-symbol levels, leftmost (bit 11) first. The pattern carries
  // the deliberate FM0 violation and ends at level 1.
  localparam logic [11:0] PREAMBLE_PAT = 12'b1101_0010_0011;

  // Last cycle index inside each timed state (cnt_q counts half-symbols).
  localparam logic [4:0] PILOT_LAST = 5'd23;
  localparam logic [4:0] PRE_REQ    = 5'd10;
  localparam logic [4:0] PRE_LAST   = 5'd11;
  localparam logic [4:0] CRC_LAST   = 5'd31;
  localparam logic [4:0] DUMMY_LAST = 5'd1;

  logic [2:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       tx_out_q, tx_out_d;
  logic       cur_bit_q, cur_bit_d;    // payload bit being (or about to be) encoded
  logic       cur_last_q, cur_last_d;  // cur_bit_q is the final payload bit

  logic       start_accept;
  logic       sample_en;
  logic       sym_bit;
  logic       go_crc;
  logic       crc_sym_bit;
  logic [3:0] pre_idx;

  // ---------------------------------------------------------------------------
  // Handshake and symbol-bit selection
  // ---------------------------------------------------------------------------
  assign start_accept = (state_q == ST_IDLE) && tx_start && !abort;

  // Request in H0, sample at the end of the following H1. The first request is
  // in the second-to-last preamble half so the first bit is ready for DATA.
  // Once the final bit is held in cur_last_q no further request is made.
  assign bit_req = ((state_q == ST_PREAMBLE) && (cnt_q == PRE_REQ)) ||
                   ((state_q == ST_DATA) && !cnt_q[0] && !cur_last_q);

  assign sample_en = ((state_q == ST_PREAMBLE) && (cnt_q == PRE_LAST)) ||
                     ((state_q == ST_DATA) && cnt_q[0] && !cur_last_q);

  // Bit value carried by the symbol currently on air; only consulted when the
  // next cycle is H1 of the same symbol.
  always_comb begin
    sym_bit = 1'b1;
    case (state_q)
      ST_PILOT: sym_bit = 1'b0;
      ST_DATA:  sym_bit = cur_bit_q;
      ST_CRC:   sym_bit = crc_sym_bit;
      default:  sym_bit = 1'b1;   // DUMMY is a data-1
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional CRC-16 generator
  // ---------------------------------------------------------------------------
`ifdef TAG_TX_CRC16_EN
  localparam logic [15:0] CRC_POLY = 16'h1021;

  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_upd;
  logic        crc_app_q, crc_app_d;
  logic        crc_fb;

  genvar gi;

  // One MSB-first LFSR step for the bit being sampled.
  assign crc_fb     = crc_q[15] ^ bit_in;
  assign crc_upd[0] = crc_fb;
  generate
    for (gi = 1; gi < 16; gi++) begin : g_crc_step
      if (CRC_POLY[gi]) begin : g_tap
        assign crc_upd[gi] = crc_q[gi-1] ^ crc_fb;
      end else begin : g_shift
        assign crc_upd[gi] = crc_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    crc_d     = crc_q;
    crc_app_d = crc_app_q;
    if (start_accept) begin
      crc_app_d = crc_append;
    end
    if (sample_en) begin
      crc_d = crc_upd;
    end else if ((state_q == ST_CRC) && cnt_q[0]) begin
      // Transmission walks the register MSB-first; shift after each symbol.
      crc_d = {crc_q[14:0], 1'b0};
    end
    // Any return to IDLE (normal end or abort) re-presets for the next reply.
    if (state_d == ST_IDLE) begin
      crc_d = 16'hFFFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q     <= 16'hFFFF;
      crc_app_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_app_q <= crc_app_d;
    end
  end

  assign go_crc      = crc_app_q;
  assign crc_sym_bit = ~crc_q[15];  // ones-complement goes on air
`else
  logic crc_append_unused;

  assign crc_append_unused = crc_append;
  assign go_crc            = 1'b0;
  assign crc_sym_bit       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 5'd1;
    cur_bit_d  = cur_bit_q;
    cur_last_d = cur_last_q;

    if (sample_en) begin
      cur_bit_d  = bit_in;
      cur_last_d = bit_last;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tx_start) begin
          state_d = trext ? ST_PILOT : ST_PREAMBLE;
        end
      end
      ST_PILOT: begin
        if (cnt_q == PILOT_LAST) begin
          state_d = ST_PREAMBLE;
          cnt_d   = '0;
        end
      end
      ST_PREAMBLE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        // Only the half-symbol phase matters here.
        cnt_d = {4'd0, ~cnt_q[0]};
        if (cnt_q[0] && cur_last_q) begin
          state_d = go_crc ? ST_CRC : ST_DUMMY;
          cnt_d   = '0;
        end
      end
      ST_CRC: begin
        if (cnt_q == CRC_LAST) begin
          state_d = ST_DUMMY;
          cnt_d   = '0;
        end
      end
      ST_DUMMY: begin
        if (cnt_q == DUMMY_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end

    if (state_d == ST_IDLE) begin
      cur_bit_d  = 1'b0;
      cur_last_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FM0 level: computed for the half-symbol that the next cycle will carry.
  // A transition into any state resets cnt to 0, so an odd cnt_d always means
  // H1 of the symbol currently in progress.
  // ---------------------------------------------------------------------------
  assign pre_idx = 4'd11 - cnt_d[3:0];

  always_comb begin
    tx_out_d = 1'b0;
    case (state_d)
      ST_PREAMBLE: tx_out_d = PREAMBLE_PAT[pre_idx];
      ST_PILOT, ST_DATA, ST_CRC, ST_DUMMY: begin
        if (!cnt_d[0]) begin
          tx_out_d = ~tx_out_q;             // every symbol starts with a flip
        end else begin
          tx_out_d = tx_out_q ^ ~sym_bit;   // data-0 flips again mid-symbol
        end
      end
      default: tx_out_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_out_q   <= 1'b0;
      cur_bit_q  <= 1'b0;
      cur_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_out_q   <= tx_out_d;
      cur_bit_q  <= cur_bit_d;
      cur_last_q <= cur_last_d;
    end
  end

  assign tx_out  = tx_out_q;
  assign tx_busy = (state_q != ST_IDLE);
  assign tx_done = (state_q == ST_DONE);

endmodule
